// File: rtl/sbox_share_ctrl.sv
// Arbitrates state (SubBytes) and key (SubWord) jobs onto one shared registered 4-byte S-box bank.
// Optional busy-cycle counter enabled by defining SBOX_SHARE_PERF_CNT_EN.
module sbox_share_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  output logic [127:0] st_out,
  output logic         st_done,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_in,
  output logic [31:0]  key_out,
  output logic         key_done,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  output logic [15:0]  busy_cnt
);

  typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KEY, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          ptr_key;
  logic          job_is_key;
  logic [1:0]    col;
  logic [127:0]  st_job;
  logic [31:0]   key_job;
  logic [95:0]   st_acc;
  logic          grant_st, grant_key;

  // Arbitration, column sequencing and bank drive; the bus idles at zero.
  always_comb begin
    state_nxt = state;
    st_ready  = 1'b0;
    key_ready = 1'b0;
    grant_st  = 1'b0;
    grant_key = 1'b0;
    sbox_in   = 32'h0;
    case (state)
      IDLE: begin
        st_ready  = 1'b1;
        key_ready = 1'b1;
        if (key_valid && (!st_valid || ptr_key)) begin
          grant_key = 1'b1;
          state_nxt = RUN_KEY;
        end else if (st_valid) begin
          grant_st  = 1'b1;
          state_nxt = RUN_ST;
        end
      end
      RUN_ST: begin
        case (col)
          2'd0:    sbox_in = st_job[127:96];
          2'd1:    sbox_in = st_job[95:64];
          2'd2:    sbox_in = st_job[63:32];
          default: sbox_in = st_job[31:0];
        endcase
        if (col == 2'd3) state_nxt = DRAIN;
      end
      RUN_KEY: begin
        sbox_in   = key_job;
        state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr_key    <= 1'b1;
      job_is_key <= 1'b0;
      col        <= 2'd0;
      st_job     <= '0;
      key_job    <= '0;
      st_acc     <= '0;
      st_out     <= '0;
      key_out    <= '0;
      st_done    <= 1'b0;
      key_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      st_done  <= 1'b0;
      key_done <= 1'b0;
      if (grant_key) begin
        key_job    <= key_in;
        job_is_key <= 1'b1;
        ptr_key    <= 1'b0;
      end
      if (grant_st) begin
        st_job     <= st_in;
        job_is_key <= 1'b0;
        ptr_key    <= 1'b1;
        col        <= 2'd0;
      end
      // The bank result seen while issuing column c belongs to column c-1.
      if (state == RUN_ST) begin
        col <= col + 2'd1;
        case (col)
          2'd1:    st_acc[95:64] <= sbox_out;
          2'd2:    st_acc[63:32] <= sbox_out;
          2'd3:    st_acc[31:0]  <= sbox_out;
          default: ;
        endcase
      end
      if (state == DRAIN) begin
        if (job_is_key) begin
          key_out  <= sbox_out;
          key_done <= 1'b1;
        end else begin
          st_out  <= {st_acc, sbox_out};
          st_done <= 1'b1;
        end
      end
    end
  end

`ifdef SBOX_SHARE_PERF_CNT_EN
  logic [15:0] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 16'h0;
    end else if (state != IDLE && busy_q != 16'hFFFF) begin
      busy_q <= busy_q + 16'h1;
    end
  end

  assign busy_cnt = busy_q;
`else
  assign busy_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Randomized self-checking bench for sbox_share_ctrl with a registered S-box bank model
// and a SubBytes/SubWord reference computed directly from the AES table.
module tb_sbox_share_ctrl;

  logic         clk, rst;
  logic         st_valid, st_ready, st_done;
  logic         key_valid, key_ready, key_done;
  logic [127:0] st_in, st_out;
  logic [31:0]  key_in, key_out, sbox_in, sbox_out;
  logic [15:0]  busy_cnt;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_st_out;
  logic [31:0]  exp_key_out;

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  sbox_share_ctrl dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in), .st_out(st_out), .st_done(st_done),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_out(key_out),
    .key_done(key_done), .sbox_in(sbox_in), .sbox_out(sbox_out), .busy_cnt(busy_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[s[8*i +: 8]];
    return r;
  endfunction

  // Shared bank: one registered lookup per byte lane per cycle.
  always @(posedge clk) sbox_out <= sub_word(sbox_in);

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic doReset();
    rst = 1'b1; st_valid = 1'b0; key_valid = 1'b0; st_in = '0; key_in = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_st_out = '0; exp_key_out = '0;
    checkOutput("rst_st_ready", 128'(st_ready), 128'(1));
    checkOutput("rst_key_ready", 128'(key_ready), 128'(1));
    checkOutput("rst_st_out", st_out, 128'h0);
    checkOutput("rst_key_out", 128'(key_out), 128'h0);
    checkOutput("rst_busy_cnt", 128'(busy_cnt), 128'h0);
    checkOutput("rst_sbox_in", 128'(sbox_in), 128'h0);
  endtask

  // Called at the negedge of the first cycle after acceptance; returns at the done cycle.
  task automatic waitDone(input bit is_key, input int want_lat, input string tag);
    int  k = 1;
    bit  seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (is_key ? st_done : key_done) checkOutput({tag, "_wrong_done"}, 128'(1), 128'(0));
      if (is_key ? key_done : st_done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput({tag, "_latency"}, seen ? 128'(k) : 128'(0), 128'(want_lat));
  endtask

  task automatic applyStimulus(input bit is_key, input logic [127:0] data, input string tag);
    if (is_key) begin
      key_valid = 1'b1; key_in = data[31:0];
      checkOutput({tag, "_ready"}, 128'(key_ready), 128'(1));
    end else begin
      st_valid = 1'b1; st_in = data;
      checkOutput({tag, "_ready"}, 128'(st_ready), 128'(1));
    end
    @(posedge clk); @(negedge clk);
    st_valid = 1'b0; key_valid = 1'b0;
    st_in = rand128(); key_in = $urandom;
    checkOutput({tag, "_first_issue"}, 128'(sbox_in), is_key ? 128'(data[31:0]) : 128'(data[127:96]));
    waitDone(is_key, is_key ? 3 : 6, tag);
    if (is_key) exp_key_out = sub_word(data[31:0]);
    else        exp_st_out  = sub_state(data);
    checkOutput({tag, "_st_out"}, st_out, exp_st_out);
    checkOutput({tag, "_key_out"}, 128'(key_out), 128'(exp_key_out));
    checkOutput({tag, "_idle_bus"}, 128'(sbox_in), 128'h0);
  endtask

  initial begin
    logic [127:0] a, c;
    logic [31:0]  b, d;
    bit           seen;
    int           exp_busy;

    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] a, c;
    logic [31:0]  b, d;
    bit           seen;
    int           exp_busy;

    doReset();
    applyStimulus(1'b0, 128'h0, "vec_zero");
    checkOutput("vec_zero_const", st_out, 128'h63636363636363636363636363636363);
    applyStimulus(1'b0, 128'h000102030405060708090a0b0c0d0e0f, "vec_seq");
    checkOutput("vec_seq_const", st_out, 128'h637c777bf26b6fc53001672bfed7ab76);
    applyStimulus(1'b1, 128'(32'h00010203), "vec_key");
    checkOutput("vec_key_const", 128'(key_out), 128'(32'h637c777b));

    // Round-robin: key wins the first tie, state next, key again after the state grant.
    doReset();
    a = {32'h11111111, rand128() >> 32};
    b = 32'h22222222;
    c = {32'h33333333, rand128() >> 32};
    d = 32'h44444444;
    st_valid = 1'b1; st_in = a; key_valid = 1'b1; key_in = b;
    @(posedge clk); @(negedge clk);
    key_valid = 1'b0; key_in = $urandom;
    checkOutput("arb_grant1_key", 128'(sbox_in), 128'(b));
    waitDone(1'b1, 3, "arb_key1");
    exp_key_out = sub_word(b);
    checkOutput("arb_key1_out", 128'(key_out), 128'(exp_key_out));
    @(posedge clk); @(negedge clk);
    st_valid = 1'b0; st_in = rand128();
    checkOutput("arb_grant2_st", 128'(sbox_in), 128'(a[127:96]));
    waitDone(1'b0, 6, "arb_st");
    exp_st_out = sub_state(a);
    checkOutput("arb_st_out", st_out, exp_st_out);
    st_valid = 1'b1; st_in = c; key_valid = 1'b1; key_in = d;
    @(posedge clk); @(negedge clk);
    st_valid = 1'b0; key_valid = 1'b0;
    checkOutput("arb_grant3_key", 128'(sbox_in), 128'(d));
    waitDone(1'b1, 3, "arb_key2");
    checkOutput("arb_key2_out", 128'(key_out), 128'(sub_word(d)));

    // Two back-to-back state jobs keep the FSM busy for ten cycles.
    doReset();
    applyStimulus(1'b0, rand128(), "busy_job1");
    applyStimulus(1'b0, rand128(), "busy_job2");
`ifdef SBOX_SHARE_PERF_CNT_EN
    exp_busy = 10;
`else
    exp_busy = 0;
`endif
    checkOutput("busy_cnt", 128'(busy_cnt), 128'(exp_busy));

    // Reset in the middle of a state job aborts it silently.
    doReset();
    applyStimulus(1'b0, rand128(), "pre_rst");
    st_valid = 1'b1; st_in = rand128();
    @(posedge clk); @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_st_out", st_out, 128'h0);
    checkOutput("abort_st_done", 128'(st_done), 128'h0);
    checkOutput("abort_sbox_in", 128'(sbox_in), 128'h0);
    checkOutput("abort_busy_cnt", 128'(busy_cnt), 128'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_st_out = '0; exp_key_out = '0;
    #1;
    checkOutput("abort_st_ready", 128'(st_ready), 128'(1));
    checkOutput("abort_key_ready", 128'(key_ready), 128'(1));
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (st_done || key_done) seen = 1'b1;
    end
    checkOutput("abort_no_done", 128'(seen), 128'(0));
    checkOutput("abort_st_out_held", st_out, 128'h0);

    // Random mix of jobs with idle gaps; outputs must hold across the other requester's jobs.
    for (int j = 0; j < 24; j++) begin
      applyStimulus(1'($urandom_range(0, 1)), rand128(), $sformatf("rnd%0d", j));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checkOutput("gap_idle_bus", 128'(sbox_in), 128'h0);
        checkOutput("gap_no_done", 128'({st_done, key_done}), 128'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sbox_share_ctrl.md
SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 SHALL have: clk  input  1  sole clock, all flops on rising edge.
REQ-002 SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: st_valid  input  1 and st_ready  output  1  state-job handshake.
REQ-004 SHALL have: st_in  input  128  state to substitute; byte0 = st_in[127:120].
REQ-005 SHALL have: st_out  output  128  substituted state, and st_done  output  1  one-cycle completion pulse.
REQ-006 SHALL have: key_valid  input  1 and key_ready  output  1  SubWord-job handshake.
REQ-007 SHALL have: key_in  input  32  word to substitute; key_out  output  32  result; key_done  output  1  completion pulse.
REQ-008 SHALL have: sbox_in  output  32  word driven to the shared 4-byte S-box bank.
REQ-009 SHALL have: sbox_out  input  32  bank result, valid exactly 1 cycle after sbox_in (bank is registered).
REQ-010 SHALL have: busy_cnt  output  16  busy-cycle count (see Configuration).

Function
REQ-011 SHALL be the only driver of the shared bank; each bank byte lane performs one S-box lookup per cycle.
REQ-012 SHALL implement FSM states IDLE, RUN_ST, RUN_KEY, DRAIN.
REQ-013 SHALL assert st_ready and key_ready only in IDLE; a job is accepted on a rising edge where ready and valid are both high.
REQ-014 SHALL, on both valids in the same IDLE cycle, grant by round-robin pointer; the pointer favours key after reset and points to the non-granted requester after every grant.
REQ-015 SHALL, on a single valid, grant that requester regardless of pointer, and still update the pointer.
REQ-016 SHALL capture st_in/key_in at acceptance; later changes or valid deassertion SHALL NOT affect the job.
REQ-017 SHALL, for a state job accepted at edge n, drive column i (st_in[127-32i -: 32]) on sbox_in in cycle n+1+i, i = 0..3 (RUN_ST).
REQ-018 SHALL capture column i result from sbox_out in cycle n+2+i into the corresponding st_out word.
REQ-019 SHALL assert st_done for exactly one cycle at cycle n+6, return to IDLE on that edge, with st_out stable from that cycle.
REQ-020 SHALL, for a key job accepted at edge n, drive key_in in cycle n+1, capture at n+2, and pulse key_done at n+3.
REQ-021 SHALL use DRAIN for the final capture cycle; no new job is accepted before the done pulse.
REQ-022 SHALL drive sbox_in to 32'h0 in every cycle it is not issuing.
REQ-023 SHALL hold st_out/key_out unchanged until the next done of the same requester.
REQ-024 SHALL never assert st_done and key_done in the same cycle.

Reset
REQ-025 SHALL on rst: state IDLE, pointer toward key, st_out=0, key_out=0, st_done=key_done=0, sbox_in=0, busy_cnt=0.
REQ-026 SHALL abort any in-flight job on rst mid-operation with no done pulse; outputs take reset values immediately.
REQ-027 SHALL assert readys in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL honour macro SBOX_SHARE_PERF_CNT_EN: when defined, busy_cnt increments by 1 each cycle the FSM is not IDLE, saturating at 16'hFFFF.
REQ-029 SHALL, when SBOX_SHARE_PERF_CNT_EN is undefined, tie busy_cnt to 16'h0 and omit the counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: st_in=128'h0 accepted at edge n -> st_done at n+6, st_out=128'h63636363636363636363636363636363.
REQ-031 SHALL cover: st_in=128'h000102030405060708090a0b0c0d0e0f -> st_out=128'h637c777bf26b6fc53001672bfed7ab76.
REQ-032 SHALL cover: key_in=32'h00010203 -> key_done 3 cycles after acceptance, key_out=32'h637c777b.
REQ-033 SHALL cover: first post-reset cycle both valids high -> key granted first, state granted next in IDLE; then both again -> key granted (pointer toggled back after state).
REQ-034 SHALL cover: rst asserted at acceptance+3 of a state job -> no st_done, st_out=0, readys high the cycle after rst release.
REQ-035 SHALL cover with macro defined: two back-to-back state jobs -> busy_cnt=10; macro undefined -> busy_cnt=0.
